wishbone_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone B3 classic arbiter.
- Sits directly downstream of the CPU's two wishbone_bus_if instances:
  - m0 is the data-bus interface.
  - m1 is the instruction-bus interface.
- The single slave port feeds the SoC interconnect (RAM/ROM/peripheral decoder).
- Grant is held for a whole cycle (cyc) and a watchdog completes hung transfers so the CPU stall releases.

---
 rtl/wishbone_arbiter_2m_pkg.sv | 23 ++
 rtl/wb_arb_watchdog.sv | 68 ++++++
 rtl/wishbone_arbiter_2m.sv | 161 ++++++++++++++++
 tb/tb_wishbone_arbiter_2m.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds the bus-state codes, the grant-state encodings and the default
// read data returned on a watchdog-forced completion.
package wishbone_arbiter_2m_pkg;

  // Bus activity codes.
  localparam logic WB_IDLE = 1'b0;
  localparam logic WB_BUSY = 1'b1;

  // Grant-state encodings; chosen one-hot so the state doubles as gnt_o.
  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_GNT0 = 2'b01;
  localparam logic [1:0] ARB_GNT1 = 2'b10;

  typedef enum logic [1:0] {
    StIdle = ARB_IDLE,
    StGnt0 = ARB_GNT0,
    StGnt1 = ARB_GNT1
  } arb_state_e;

  localparam logic [31:0] WB_TIMEOUT_DATA = 32'h0000_0000;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Transfer watchdog for the Wishbone arbiter.
// Counts strobed cycles without an ack; at the limit it forces a one-cycle
// completion and then latches timed_out until the grant changes.
// Ports:
//   clk, rst   clock, async active-high reset
//   clear      grant state is changing this edge
//   stb        slave strobe as driven by the arbiter
//   ack        slave ack
//   force_ack  forced completion this cycle (also the timeout pulse)
//   timed_out  transfer was forced; keeps the slave side quiet
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stb,
  input  logic ack,
  output logic force_ack,
  output logic timed_out
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clear, stb, ack};
      assign force_ack = 1'b0;
      assign timed_out = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          timed_out_q, timed_out_d;

      always_comb begin
        // A real ack in the limit cycle wins over the forced one.
        force_ack   = stb & ~ack & (cnt_q == LIMIT);
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        if (clear || ack) begin
          cnt_d = '0;
        end else if (stb && (cnt_q != SAT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (clear) begin
          timed_out_d = 1'b0;
        end else if (force_ack) begin
          timed_out_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q       <= '0;
          timed_out_q <= 1'b0;
        end else begin
          cnt_q       <= cnt_d;
          timed_out_q <= timed_out_d;
        end
      end

      assign timed_out = timed_out_q;
    end
  endgenerate

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// Two-master, one-slave Wishbone B3 classic arbiter.
// m0 is the CPU data bus, m1 the instruction bus; the slave port feeds the
// SoC interconnect. A grant is held for the whole cyc; a watchdog completes
// hung transfers so the CPU stall releases.
// Ports:
//   clk, rst          clock, async active-high reset
//   mX_*_i / mX_*_o   master X Wishbone port (X = 0, 1)
//   s_*_o / s_*_i     slave Wishbone port
//   gnt_o             one-hot current grant, 00 = idle
//   timeout_o         one-cycle pulse on a forced completion
module wishbone_arbiter_2m
  import wishbone_arbiter_2m_pkg::*;
#(
  parameter int unsigned    AW           = 32,
  parameter int unsigned    DW           = 32,
  parameter int unsigned    RR           = 1,
  parameter int unsigned    TIMEOUT      = 256,
  parameter logic [DW-1:0]  TIMEOUT_DATA = DW'(WB_TIMEOUT_DATA)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  output logic [DW-1:0] m0_data_o,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic          m0_ack_o,

  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  output logic [DW-1:0] m1_data_o,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic          m1_ack_o,

  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  input  logic [DW-1:0] s_data_i,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o,
  output logic          timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;  // 1 = m1 held the last grant
  logic       force_ack, timed_out;

  // Next-state: arbitration from idle, direct handover on release.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if ((RR != 0) && !last_gnt_q) state_d = StGnt1;
          else                          state_d = StGnt0;
        end else if (m0_cyc_i) begin
          state_d = StGnt0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (!m0_cyc_i) state_d = m1_cyc_i ? StGnt1 : StIdle;
      end
      StGnt1: begin
        if (!m1_cyc_i) state_d = m0_cyc_i ? StGnt0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      if (state_d == StGnt0) last_gnt_d = 1'b0;
      if (state_d == StGnt1) last_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_d != state_q),
    .stb       (s_stb_o),
    .ack       (s_ack_i),
    .force_ack (force_ack),
    .timed_out (timed_out)
  );

  // Slave-side routing; cyc/stb drop combinationally on abort or timeout.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i & ~timed_out;
        s_stb_o  = m0_stb_i & m0_cyc_i & ~timed_out;
      end
      StGnt1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i & ~timed_out;
        s_stb_o  = m1_stb_i & m1_cyc_i & ~timed_out;
      end
      default: ;
    endcase
  end

  // Master-side return path; kept apart from the slave side since force_ack
  // is derived from s_stb_o.
  always_comb begin
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    unique case (state_q)
      StGnt0: begin
        m0_ack_o  = (s_ack_i & m0_cyc_i & ~timed_out) | force_ack;
        m0_data_o = force_ack ? TIMEOUT_DATA : s_data_i;
      end
      StGnt1: begin
        m1_ack_o  = (s_ack_i & m1_cyc_i & ~timed_out) | force_ack;
        m1_data_o = force_ack ? TIMEOUT_DATA : s_data_i;
      end
      default: ;
    endcase
  end

  assign gnt_o     = state_q;
  assign timeout_o = force_ack;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// all inputs; inputs change on the falling edge, outputs are checked 1ns later.
module tb_wishbone_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        m0_ack, m1_ack, s_we, s_stb, s_cyc, tout;
  logic [1:0]  gnt;

  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_sel;
  logic        fp_m0_ack, fp_m1_ack, fp_s_we, fp_s_stb, fp_s_cyc, fp_tout;
  logic [1:0]  fp_gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wishbone_arbiter_2m #(.RR(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_data_o(m0_rdata), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_data_o(m1_rdata), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack),
    .s_addr_o(s_addr), .s_data_o(s_wdata), .s_data_i(s_rdata), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack),
    .gnt_o(gnt), .timeout_o(tout)
  );

  wishbone_arbiter_2m #(.RR(0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_data_o(fp_m0_rdata), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(fp_m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_data_o(fp_m1_rdata), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(fp_m1_ack),
    .s_addr_o(fp_s_addr), .s_data_o(fp_s_wdata), .s_data_i(s_rdata), .s_we_o(fp_s_we),
    .s_sel_o(fp_s_sel), .s_stb_o(fp_s_stb), .s_cyc_o(fp_s_cyc), .s_ack_i(s_ack),
    .gnt_o(fp_gnt), .timeout_o(fp_tout)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] data);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_wdata = data; m0_sel = 4'hf;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] data);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_wdata = data; m1_sel = 4'hf;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    s_ack = 1'b0; s_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    s_ack = 1'b0; s_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_tout", tout, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Single m0 read, slave acks in the third strobe cycle.
    @(negedge clk); set_m0(1, 1, 0, 32'h1000, 0); #1;
    check("rd_gnt_idle", gnt, 2'b00);
    check("rd_stb_latency", s_stb, 1'b0);
    @(negedge clk); #1;
    check("rd_gnt", gnt, 2'b01);
    check("rd_s_stb", s_stb, 1'b1);
    check("rd_s_addr", s_addr, 32'h1000);
    @(negedge clk); #1;
    check("rd_no_ack", m0_ack, 1'b0);
    @(negedge clk); s_ack = 1'b1; s_rdata = 32'hA5A5_0001; #1;
    check("rd_ack", m0_ack, 1'b1);
    check("rd_data", m0_rdata, 32'hA5A5_0001);
    check("rd_m1_ack", m1_ack, 1'b0);
    @(negedge clk); s_ack = 1'b0; s_rdata = '0; set_m0(0, 0, 0, 0, 0); #1;
    check("rd_cyc_drop", s_cyc, 1'b0);
    @(negedge clk); #1;
    check("rd_idle", gnt, 2'b00);

    // Simultaneous requests from reset.
    do_reset();
    set_m0(1, 1, 0, 32'h10, 0); set_m1(1, 1, 0, 32'h20, 0); #1;
    check("sim_idle", gnt, 2'b00);
    @(negedge clk); s_ack = 1'b1; #1;
    check("sim_g1", gnt, 2'b01);
    check("sim_g1_fp", fp_gnt, 2'b01);
    check("sim_m0_ack", m0_ack, 1'b1);
    check("sim_m1_ack0", m1_ack, 1'b0);
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0); #1;
    check("sim_s_stb_rel", s_stb, 1'b0);
    @(negedge clk); s_ack = 1'b1; #1;
    check("sim_g2_direct", gnt, 2'b10);
    check("sim_g2_fp", fp_gnt, 2'b10);
    check("sim_m1_ack", m1_ack, 1'b1);
    @(negedge clk); s_ack = 1'b0; set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("sim_gap", gnt, 2'b00);
    set_m0(1, 1, 0, 32'h10, 0); set_m1(1, 1, 0, 32'h20, 0);
    @(negedge clk); #1;
    check("sim_g3", gnt, 2'b01);
    check("sim_g3_fp", fp_gnt, 2'b01);
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("sim_gap2", gnt, 2'b00);
    set_m0(1, 1, 0, 32'h10, 0); set_m1(1, 1, 0, 32'h20, 0);
    @(negedge clk); #1;
    check("sim_g4_rr", gnt, 2'b10);
    check("sim_g4_fp", fp_gnt, 2'b01);
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("sim_end_idle", gnt, 2'b00);

    // Grant hold: three m1 writes under one cyc while m0 waits.
    @(negedge clk); set_m1(1, 0, 1, 32'h2000, 0);
    @(negedge clk); #1;
    check("hold_gnt", gnt, 2'b10);
    set_m0(1, 1, 0, 32'h1234, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_m1(1, 1, 1, 32'h2000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
      s_ack = 1'b1; #1;
      check("hold_gnt_ack", gnt, 2'b10);
      check("hold_m1_ack", m1_ack, 1'b1);
      check("hold_m0_ack", m0_ack, 1'b0);
      check("hold_wdata", s_wdata, 32'hC0DE_0000 + 32'(k));
      check("hold_we", s_we, 1'b1);
      @(negedge clk); set_m1(1, 0, 1, 32'h2000, 0); s_ack = 1'b0; #1;
      check("hold_gnt_gap", gnt, 2'b10);
    end
    @(negedge clk); set_m1(0, 0, 0, 0, 0); #1;
    check("hold_rel_cycle", gnt, 2'b10);
    @(negedge clk); #1;
    check("hold_m0_gnt", gnt, 2'b01);
    check("hold_m0_gnt_fp", fp_gnt, 2'b01);
    check("hold_m0_addr", s_addr, 32'h1234);
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("hold_idle", gnt, 2'b00);

    // Timeout: non-acking slave, forced completion in the 8th strobe cycle.
    s_rdata = 32'hDEAD_BEEF;
    set_m0(1, 1, 0, 32'h3000, 0);
    @(negedge clk); #1;
    check("to_s_stb", s_stb, 1'b1);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk); #1;
      check("to_early", {m0_ack, tout}, 2'b00);
    end
    @(negedge clk); #1;
    check("to_ack", m0_ack, 1'b1);
    check("to_data", m0_rdata, 32'h0000_0000);
    check("to_pulse", tout, 1'b1);
    @(negedge clk); #1;
    check("to_after_stb", s_stb, 1'b0);
    check("to_after_cyc", s_cyc, 1'b0);
    check("to_after_pulse", tout, 1'b0);
    check("to_after_ack", m0_ack, 1'b0);
    @(negedge clk); #1;
    check("to_still_low", s_stb, 1'b0);
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("to_idle", gnt, 2'b00);

    // Timeout variant: real ack in the limit cycle wins.
    set_m0(1, 1, 0, 32'h3000, 0);
    for (int i = 1; i <= 7; i++) @(negedge clk);
    @(negedge clk); s_ack = 1'b1; #1;
    check("tov_ack", m0_ack, 1'b1);
    check("tov_data", m0_rdata, 32'hDEAD_BEEF);
    check("tov_no_pulse", tout, 1'b0);
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("tov_idle", gnt, 2'b00);

    // Abort: m0 drops cyc while the slave acks.
    set_m0(1, 1, 0, 32'h4000, 0);
    @(negedge clk); #1;
    check("ab_stb", s_stb, 1'b1);
    set_m0(0, 0, 0, 32'h4000, 0); s_ack = 1'b1; #1;
    check("ab_no_ack", m0_ack, 1'b0);
    check("ab_no_stb", s_stb, 1'b0);
    @(negedge clk); s_ack = 1'b0; #1;
    check("ab_idle", gnt, 2'b00);

    // Async reset between edges during GNT1.
    set_m1(1, 1, 0, 32'h5000, 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check("ar_gnt1", gnt, 2'b10);
    check("ar_m1_ack", m1_ack, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_gnt", gnt, 2'b00);
    check("ar_m1_ack0", m1_ack, 1'b0);
    check("ar_m1_data", m1_rdata, 32'h0);
    check("ar_s_bus", {s_stb, s_cyc, s_we}, 3'b000);
    check("ar_s_addr", s_addr, 32'h0);
    check("ar_fp_gnt", fp_gnt, 2'b00);
    s_ack = 1'b0;
    @(negedge clk); rst = 1'b0; set_m0(1, 1, 0, 32'h6000, 0); #1;
    check("ar_rel_idle", gnt, 2'b00);
    @(negedge clk); #1;
    check("ar_tie_m0", gnt, 2'b01);
    check("ar_tie_m0_fp", fp_gnt, 2'b01);
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
